// File: rtl/ws2812_pixel_feeder.sv
// Double-buffered GRB pixel store feeding a WS2812 serializer one pixel per
// valid/ready handshake, one frame per frame-timer tick.
module ws2812_pixel_feeder #(
   parameter int LED_NUM   = 8,
   parameter int ADDR_W    = 8,
   parameter int CLK_FRE   = 27_000_000,
   parameter int FRAME_CYC = CLK_FRE / 100
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [23:0]       wr_data,
   input  logic              commit,
   output logic [23:0]       pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_last,
   output logic              frame_busy,
   output logic              frame_overrun
);
   localparam int IDX_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
   localparam int CNT_W = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
   localparam logic [ADDR_W:0]  LED_LIM  = (ADDR_W + 1)'(LED_NUM);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LED_NUM - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_OFFER = 2'd2
   } state_t;

   state_t           state_r, state_s;
   logic [23:0]      mem_r [0:1][0:LED_NUM-1];
   logic [CNT_W-1:0] cnt_r;
   logic [IDX_W-1:0] idx_r, idx_s;
   logic             front_r, front_s;
   logic             pend_r, pend_s;
   logic [23:0]      pix_data_r, pix_data_s;
   logic             pix_valid_r, pix_valid_s;
   logic             pix_last_r, pix_last_s;
   logic             busy_r, busy_s;
   logic             overrun_r, overrun_s;
   logic             tick_s;
   logic             swap_s;
   logic             wr_ok_s;
   logic [IDX_W-1:0] wr_idx_s;

   assign tick_s   = (cnt_r == CNT_LAST);
   assign swap_s   = tick_s & (state_r == ST_IDLE) & pend_r;
   assign wr_ok_s  = wr_en & ({1'b0, wr_addr} < LED_LIM);
   assign wr_idx_s = wr_addr[IDX_W-1:0];

   assign pix_data      = pix_data_r;
   assign pix_valid     = pix_valid_r;
   assign pix_last      = pix_last_r;
   assign frame_busy    = busy_r;
   assign frame_overrun = overrun_r;

   // Free-running frame timer
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (tick_s) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   // Host writes always target the back bank; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         mem_r[~front_r][wr_idx_s] <= wr_data;
      end
   end

   // Frame sequencer next-state and output logic
   always_comb begin
      state_s     = state_r;
      idx_s       = idx_r;
      pix_data_s  = pix_data_r;
      pix_valid_s = pix_valid_r;
      pix_last_s  = pix_last_r;
      busy_s      = busy_r;
      front_s     = front_r ^ swap_s;
      pend_s      = commit | (pend_r & ~swap_s);
      overrun_s   = overrun_r | (tick_s & (state_r != ST_IDLE));
      case (state_r)
         ST_IDLE: begin
            if (tick_s) begin
               state_s = ST_LOAD;
               idx_s   = '0;
               busy_s  = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            pix_data_s  = mem_r[front_r][idx_r];
            pix_last_s  = (idx_r == IDX_LAST);
            pix_valid_s = 1'b1;
            state_s     = ST_OFFER;
         end
         ST_OFFER: begin
            if (pix_ready) begin
               pix_valid_s = 1'b0;
               pix_last_s  = 1'b0;
               if (pix_last_r) begin
                  state_s = ST_IDLE;
                  busy_s  = 1'b0;
               end else begin
                  state_s = ST_LOAD;
                  idx_s   = idx_r + IDX_W'(1);
               end
            end else begin
               state_s = ST_OFFER;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         idx_r       <= '0;
         front_r     <= 1'b0;
         pend_r      <= 1'b0;
         pix_data_r  <= 24'h000000;
         pix_valid_r <= 1'b0;
         pix_last_r  <= 1'b0;
         busy_r      <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         idx_r       <= idx_s;
         front_r     <= front_s;
         pend_r      <= pend_s;
         pix_data_r  <= pix_data_s;
         pix_valid_r <= pix_valid_s;
         pix_last_r  <= pix_last_s;
         busy_r      <= busy_s;
         overrun_r   <= overrun_s;
      end
   end
endmodule

// File: doc/ws2812_pixel_feeder.md
Name: ws2812_pixel_feeder

Overview:
- Upstream stage of the WS2812 serializer: holds one 24-bit GRB colour per LED in a double-buffered store and streams one pixel per valid/ready handshake at a fixed frame rate.
- Host logic (key/UDP control) writes the back bank and requests a commit; the swap happens only at a frame boundary, so a frame never mixes old and new colours.

Parameters:
- LED_NUM, 8, number of LEDs in the chain (1..256).
- ADDR_W, 8, width of the pixel address.
- CLK_FRE, 27_000_000, clk frequency in Hz.
- FRAME_CYC, CLK_FRE/100, clk cycles per frame period (100 Hz default); must be ≥ 4.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- wr_en  input  1  write strobe for the back bank.
- wr_addr  input  ADDR_W  LED index to write.
- wr_data  input  24  colour in {G,R,B} order, MSB first.
- commit  input  1  one-cycle pulse: swap banks at the next frame boundary.
- pix_data  output  24  current pixel colour.
- pix_valid  output  1  pix_data is valid.
- pix_ready  input  1  serializer accepts the pixel.
- pix_last  output  1  qualifies the final pixel of a frame (index LED_NUM-1).
- frame_busy  output  1  high from frame start until the last pixel is accepted.
- frame_overrun  output  1  sticky flag: a frame tick arrived while busy.

Behaviour:
- Reset values:
  - Outputs: pix_valid=0, pix_last=0, pix_data=0, frame_busy=0, frame_overrun=0.
  - Internal: state=IDLE, front bank=0, commit_pend=0, frame counter=0.
  - Bank contents are not cleared.
- Frame timer:
  - Free-running counter 0..FRAME_CYC-1.
  - tick is a one-cycle pulse when counter==FRAME_CYC-1; the counter then wraps to 0.
- Writes:
  - wr_en with wr_addr<LED_NUM writes the back bank in that cycle.
  - wr_addr≥LED_NUM is ignored.
  - Writes are accepted in every state.
- Commit:
  - A commit pulse sets commit_pend.
  - The swap happens on the tick that starts the next frame, only when state==IDLE; commit_pend then clears.
  - Commit and wr_en in the same cycle: the write lands in the bank being committed.
- State machine:
  - IDLE: on tick → LOAD, index=0, frame_busy=1; apply a pending swap in the same cycle.
  - LOAD: one-cycle synchronous read of front bank[index] → OFFER.
  - OFFER: pix_valid=1; pix_data and pix_last are held stable until pix_valid&pix_ready.
    - On handshake, pix_valid drops the next cycle.
    - If index==LED_NUM-1 → IDLE and frame_busy=0.
    - Otherwise index+1 → LOAD.
- Latency:
  - First pix_valid is 2 cycles after tick.
  - Each subsequent pix_valid is 2 cycles after the previous handshake.
- pix_valid is never withdrawn without a handshake, except by rst.
- pix_ready while pix_valid=0 has no effect.
- A tick while state≠IDLE is dropped and sets frame_overrun=1 (cleared only by rst); the frame in progress completes normally.
- Pixel index wraps only through the IDLE transition, never mid-frame.
- rst mid-frame:
  - pix_valid goes low in the next cycle and the partial frame is abandoned.
  - The serializer's own reset/latch gap ends the strip frame.

Test Plan:
- LED_NUM=4, FRAME_CYC=200; write addrs 0..3 = 0x010000, 0x000100, 0x000001, 0xFFFFFF; commit; pix_ready tied 1 → the frame after the commit tick emits those 4 values in order, pix_last only on 0xFFFFFF, frame_busy low afterwards.
- Backpressure: pix_ready low for 50 cycles during pixel 1 → pix_data stays 0x000100 with pix_valid high; no skip or duplicate after ready rises.
- Write addr 2 = 0x123456 without commit → next two frames still emit 0x000001 at index 2; commit → the following frame emits 0x123456.
- pix_ready held 0 for 300 cycles (frame spans a tick) → frame_overrun=1 and stays 1; the frame completes once ready returns; a new frame starts on the next tick.
- rst asserted during pixel 2 of a frame → pix_valid=0, frame_busy=0 next cycle; the next frame emits from index 0 with bank contents intact.
- wr_addr=4 with LED_NUM=4, then commit → no change to emitted data; commit and wr_en to addr 0 in the same cycle → the new addr-0 value appears in the next frame.
